// File: rtl/switch_event_gen.sv
// switch_event_gen: debounces a raw switch pin into press/release pulses and a clean level.
// Define SW_LONG_PRESS_EN to add the oSwLong held-press pulse.
module switch_event_gen #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter bit SW_ACTIVE_LOW   = 1'b1,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iSwRaw,
   output logic oSwDown,
   output logic oSwUp,
`ifdef SW_LONG_PRESS_EN
   output logic oSwLong,
`endif
   output logic oSwLevel
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
   localparam logic REL = SW_ACTIVE_LOW;
   typedef enum logic [1:0] {S_UP, S_CHK_DN, S_DOWN, S_CHK_UP} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic sync1_q, sync2_q, sw_p;
   logic down_q, down_d, up_q, up_d, level_q, level_d;
   assign sw_p    = sync2_q ^ REL;
   assign cnt_inc = (cnt_q < CNT_MAX) ? cnt_q + CW'(1) : cnt_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      down_d  = 1'b0;
      up_d    = 1'b0;
      level_d = level_q;
      case (state_q)
         S_UP: begin
            state_d = sw_p ? S_CHK_DN : S_UP;
            cnt_d   = sw_p ? CW'(1) : '0;
         end
         S_CHK_DN:
            if (!sw_p) begin
               state_d = S_UP;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_DOWN;
               cnt_d   = '0;
               level_d = 1'b1;
               down_d  = 1'b1;
            end else
               cnt_d = cnt_inc;
         S_DOWN: begin
            state_d = sw_p ? S_DOWN : S_CHK_UP;
            cnt_d   = sw_p ? '0 : CW'(1);
         end
         S_CHK_UP:
            if (sw_p) begin
               state_d = S_DOWN;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_UP;
               cnt_d   = '0;
               level_d = 1'b0;
               up_d    = 1'b1;
            end else
               cnt_d = cnt_inc;
      endcase
   end
   always_ff @(posedge iClk) begin
      if (iRst) begin
         sync1_q <= REL;
         sync2_q <= REL;
         state_q <= S_UP;
         cnt_q   <= '0;
         down_q  <= 1'b0;
         up_q    <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= iSwRaw;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         down_q  <= down_d;
         up_q    <= up_d;
         level_q <= level_d;
      end
   end
   assign oSwDown  = down_q;
   assign oSwUp    = up_q;
   assign oSwLevel = level_q;
`ifdef SW_LONG_PRESS_EN
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
   logic [HW-1:0] hold_q, hold_d;
   logic long_q, long_d, holding;
   // Bounces back from S_CHK_UP keep counting; only a fresh press clears the hold time.
   always_comb begin
      holding = (state_q == S_DOWN) || (state_q == S_CHK_UP);
      hold_d  = (state_q == S_CHK_DN && state_d == S_DOWN) ? '0 :
                (holding && hold_q < HOLD_MAX) ? hold_q + HW'(1) : hold_q;
      long_d  = holding && hold_q == HOLD_LAST && state_d != S_UP;
   end
   always_ff @(posedge iClk) begin
      if (iRst) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end
   assign oSwLong = long_q;
`endif
endmodule

// File: tb/tb_switch_event_gen.sv
// tb_switch_event_gen: vector table plus per-cycle scoreboard against a run-length debounce model.
module tb_switch_event_gen;
   localparam int D = 8;
   localparam int L = 40;
   logic clk = 1'b0, rst = 1'b1, raw = 1'b1;
   logic dn, up, lvl;
`ifdef SW_LONG_PRESS_EN
   logic lng;
`endif
   int errors = 0, checks = 0;
   int seg_dn, seg_up, seg_long, f_dn, f_up, f_long;
   always #5 clk = ~clk;
   switch_event_gen #(.DEBOUNCE_CYCLES(D), .SW_ACTIVE_LOW(1'b1), .LONG_CYCLES(L)) dut (
      .iClk(clk),
      .iRst(rst),
      .iSwRaw(raw),
      .oSwDown(dn),
      .oSwUp(up),
`ifdef SW_LONG_PRESS_EN
      .oSwLong(lng),
`endif
      .oSwLevel(lvl)
   );
   typedef struct {logic dn; logic up; logic lvl;} exp_t;
   exp_t sb_q[$];
   exp_t e_m, e_c;
   logic m_s1 = 1'b1, m_s2 = 1'b1, m_lvl = 1'b0, m_p;
   int m_run = 0;
   bit m_live = 0;
   always @(posedge clk) begin
      if (rst) begin
         m_s1 = 1'b1;
         m_s2 = 1'b1;
         m_lvl = 1'b0;
         m_run = 0;
         e_m = '{1'b0, 1'b0, 1'b0};
         m_live = 1;
      end else begin
         m_p = ~m_s2;
         m_s2 = m_s1;
         m_s1 = raw;
         e_m = '{1'b0, 1'b0, m_lvl};
         if (m_p != m_lvl) begin
            m_run++;
            if (m_run == D) begin
               m_lvl = m_p;
               m_run = 0;
               e_m = '{m_p, !m_p, m_p};
            end
         end else
            m_run = 0;
      end
      if (m_live) sb_q.push_back(e_m);
   end
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         e_c = sb_q.pop_front();
         checks++;
         if ({dn, up, lvl} !== {e_c.dn, e_c.up, e_c.lvl}) begin
            errors++;
            $display("FAIL scoreboard t=%0t dn/up/lvl got=%b%b%b exp=%b%b%b", $time, dn, up, lvl, e_c.dn, e_c.up, e_c.lvl);
         end
      end
   end
   bit last_dn = 0;
   always @(negedge clk) begin
      if (dn || up) begin
         checks++;
         if ((dn && up) || (dn && last_dn) || (up && !last_dn)) begin
            errors++;
            $display("FAIL alternation t=%0t got dn=%b up=%b last_dn=%b exp alternating single events", $time, dn, up, last_dn);
         end
         last_dn = dn;
      end
      if (rst) last_dn = 0;
   end
   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask
   task automatic hold(input logic v, input int n);
      raw = v;
      seg_dn = 0; seg_up = 0; seg_long = 0;
      f_dn = -1; f_up = -1; f_long = -1;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (dn) begin seg_dn++; if (f_dn < 0) f_dn = i; end
         if (up) begin seg_up++; if (f_up < 0) f_up = i; end
`ifdef SW_LONG_PRESS_EN
         if (lng) begin seg_long++; if (f_long < 0) f_long = i; end
`endif
      end
   endtask
   typedef struct {int w; int exp_dn; int exp_up;} vec_t;
   vec_t vecs[7];
   initial begin
      int tdn, tup, tot, n;
      logic v;
      vecs[0] = '{1, 0, 0};
      vecs[1] = '{4, 0, 0};
      vecs[2] = '{7, 0, 0};
      vecs[3] = '{8, 1, 1};
      vecs[4] = '{9, 1, 1};
      vecs[5] = '{15, 1, 1};
      vecs[6] = '{25, 1, 1};
      repeat (3) @(negedge clk);
      check("reset_dn", dn, 0);
      check("reset_up", up, 0);
      check("reset_lvl", lvl, 0);
      rst = 1'b0;
      hold(1'b1, 100);
      check("idle_dn", seg_dn, 0);
      check("idle_up", seg_up, 0);
      check("idle_lvl", lvl, 0);
      hold(1'b0, 20);
      check("press_latency", f_dn, 10);
      check("press_count", seg_dn, 1);
      check("press_lvl", lvl, 1);
      hold(1'b1, 20);
      check("release_latency", f_up, 10);
      check("release_count", seg_up, 1);
      check("release_lvl", lvl, 0);
      tdn = 0;
      hold(1'b0, 3); tdn += seg_dn;
      hold(1'b1, 2); tdn += seg_dn;
      hold(1'b0, 5); tdn += seg_dn;
      hold(1'b1, 2); tdn += seg_dn;
      hold(1'b0, 7); tdn += seg_dn;
      hold(1'b1, 2); tdn += seg_dn;
      check("bounce_no_dn", tdn, 0);
      hold(1'b0, 20);
      check("bounce_final_latency", f_dn, 10);
      hold(1'b1, 20);
      check("bounce_final_up", seg_up, 1);
      foreach (vecs[k]) begin
         hold(1'b0, vecs[k].w);
         tdn = seg_dn; tup = seg_up;
         hold(1'b1, 30);
         tdn += seg_dn; tup += seg_up;
         check($sformatf("vec_w%0d_dn", vecs[k].w), tdn, vecs[k].exp_dn);
         check($sformatf("vec_w%0d_up", vecs[k].w), tup, vecs[k].exp_up);
      end
      rst = 1'b1;
      raw = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      hold(1'b0, 15);
      check("held_reset_latency", f_dn, 10);
      hold(1'b1, 4);
      rst = 1'b1;
      @(negedge clk);
      check("abort_dn", dn, 0);
      check("abort_up", up, 0);
      check("abort_lvl", lvl, 0);
      rst = 1'b0;
      hold(1'b1, 20);
      check("abort_no_up", seg_up, 0);
      check("abort_no_dn", seg_dn, 0);
      tot = 0;
      v = 1'b1;
      while (tot < 2000) begin
         v = ~v;
         n = $urandom_range(1, 14);
         hold(v, n);
         tot += n;
      end
      hold(1'b1, 30);
      check("random_settle_lvl", lvl, 0);
`ifdef SW_LONG_PRESS_EN
      hold(1'b0, 60);
      check("long_press_dn", f_dn, 10);
      check("long_count", seg_long, 1);
      check("long_latency", f_long, 50);
      hold(1'b1, 30);
      check("long_none_on_release", seg_long, 0);
      hold(1'b0, 30);
      check("short_no_long", seg_long, 0);
      hold(1'b1, 30);
      check("short_no_long_rel", seg_long, 0);
      check("short_up", seg_up, 1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
